// File: rtl/bcd_counter_pkg.sv
// Shared constants and helpers for the BCD tick counter: digit limits,
// active-low seven-segment patterns and load-value clamping.
package bcd_counter_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  // Active-low segments ordered {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_LUT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_tick_counter_if.sv
// Control/status bundle between the BCD tick counter and its user.
// Optional hex segment output exists only when SEVEN_SEG_EN is defined.
interface bcd_tick_counter_if #(parameter int DIGITS = 4);

  logic                  en;
  logic                  up_dn;
  logic                  clear;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   bcd;
  logic                  tick;
  logic                  rollover;
`ifdef SEVEN_SEG_EN
  logic [7*DIGITS-1:0]   hex;

  modport master (output en, up_dn, clear, load, load_val,
                  input  bcd, tick, rollover, hex);
  modport slave  (input  en, up_dn, clear, load, load_val,
                  output bcd, tick, rollover, hex);
`else
  modport master (output en, up_dn, clear, load, load_val,
                  input  bcd, tick, rollover);
  modport slave  (input  en, up_dn, clear, load, load_val,
                  output bcd, tick, rollover);
`endif

endinterface

// File: rtl/bcd_digit.sv
// One decimal digit of the cascade: clear > load > step, wraps 9<->0.
// cout flags the digit that will wrap on its next step in the current direction.
module bcd_digit
  import bcd_counter_pkg::*;
(
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       step,
  input  logic       up_dn,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_digit,
  output logic [3:0] q,
  output logic       cout
);

  logic [3:0] q_q, q_d;

  // NOTE: default assignment first keeps every path driven, so no latch is inferred.
  always_comb begin
    q_d = q_q;
    if (clear) begin
      q_d = BCD_MIN;
    end else if (load) begin
      q_d = clamp_bcd(load_digit);
    end else if (step) begin
      if (up_dn) q_d = (q_q == BCD_MAX) ? BCD_MIN : q_q + 4'd1;
      else       q_d = (q_q == BCD_MIN) ? BCD_MAX : q_q - 4'd1;
    end
  end

  // NOTE: non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) q_q <= BCD_MIN;
    else       q_q <= q_d;
  end

  assign q    = q_q;
  assign cout = up_dn ? (q_q == BCD_MAX) : (q_q == BCD_MIN);

endmodule

// File: rtl/bcd_tick_counter.sv
// Prescaled multi-digit BCD up/down counter with registered tick/rollover strobes.
// Define SEVEN_SEG_EN to add the active-low seven-segment hex output.
module bcd_tick_counter
  import bcd_counter_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1,
  parameter int DIGITS  = 4
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  bcd_tick_counter_if.slave  bus
);

  localparam int             PRESCALE   = CLK_HZ / TICK_HZ;
  localparam int             PW         = $clog2(PRESCALE);
  localparam logic [PW-1:0]  PRESC_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0]       presc_q, presc_d;
  logic                tick_q, tick_d;
  logic                roll_q, roll_d;
  logic                terminal, tick_int;
  logic [DIGITS-1:0]   step, cout;
  logic [4*DIGITS-1:0] bcd_w;

  // A load or clear on the terminal edge swallows the tick
  assign terminal = bus.en && (presc_q == PRESC_LAST);
  assign tick_int = terminal && !bus.clear && !bus.load;

  always_comb begin
    logic acc;
    presc_d = presc_q;
    if (bus.clear || bus.load) presc_d = '0;
    else if (bus.en)           presc_d = terminal ? '0 : presc_q + PW'(1);

    acc  = 1'b1;
    step = '0;
    for (int i = 0; i < DIGITS; i++) begin
      step[i] = tick_int & acc;
      acc     = acc & cout[i];
    end

    tick_d = tick_int;
    roll_d = tick_int & (&cout);
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
      roll_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
      roll_q  <= roll_d;
    end
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .CLOCK_50   (CLOCK_50),
      .reset      (reset),
      .step       (step[i]),
      .up_dn      (bus.up_dn),
      .clear      (bus.clear),
      .load       (bus.load),
      .load_digit (bus.load_val[4*i +: 4]),
      .q          (bcd_w[4*i +: 4]),
      .cout       (cout[i])
    );
  end

  assign bus.bcd      = bcd_w;
  assign bus.tick     = tick_q;
  assign bus.rollover = roll_q;

`ifdef SEVEN_SEG_EN
  for (genvar i = 0; i < DIGITS; i++) begin : g_seg
    assign bus.hex[7*i +: 7] = (bcd_w[4*i +: 4] > BCD_MAX) ? 7'h7F : SEG_LUT[bcd_w[4*i +: 4]];
  end
`endif

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Self-checking bench for bcd_tick_counter (PRESCALE=10, two digits) against
// an integer-count reference model.
module tb_bcd_tick_counter;

  localparam int PRESCALE = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;

  bcd_tick_counter_if #(.DIGITS(2)) bus ();

  bcd_tick_counter #(.CLK_HZ(10), .TICK_HZ(1), .DIGITS(2)) dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int   m_cnt, m_ph;
  logic m_tick, m_roll;
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'((v / 10) % 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  task automatic drive(input logic en, input logic up, input logic clr,
                       input logic ld, input logic [7:0] val);
    bus.en = en; bus.up_dn = up; bus.clear = clr; bus.load = ld; bus.load_val = val;
  endtask

  task automatic model_reset();
    m_cnt = 0; m_ph = 0; m_tick = 1'b0; m_roll = 1'b0;
  endtask

  // Apply one clock edge to the model, then advance the DUT and settle.
  task automatic adv();
    int d0, d1;
    m_tick = 1'b0;
    m_roll = 1'b0;
    if (bus.clear) begin
      m_cnt = 0; m_ph = 0;
    end else if (bus.load) begin
      d0 = int'(bus.load_val[3:0]); d1 = int'(bus.load_val[7:4]);
      if (d0 > 9) d0 = 9;
      if (d1 > 9) d1 = 9;
      m_cnt = d1 * 10 + d0; m_ph = 0;
    end else if (bus.en) begin
      if (m_ph == PRESCALE - 1) begin
        m_ph = 0; m_tick = 1'b1;
        if (bus.up_dn) begin m_roll = (m_cnt == 99); m_cnt = (m_cnt + 1) % 100;  end
        else           begin m_roll = (m_cnt == 0);  m_cnt = (m_cnt + 99) % 100; end
      end else begin
        m_ph++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(0, 1, 0, 0, 8'h00);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.bcd, bus.tick, bus.rollover} !== 10'h000) begin
      n_bad++;
      $display("FAIL reset_state: got bcd=%h tick=%b roll=%b, want 00/0/0", bus.bcd, bus.tick, bus.rollover);
    end
    rst = 1'b0;
    model_reset();

    drive(0, 1, 0, 1, 8'h37);
    adv();
    drive(1, 1, 0, 0, 8'h00);
    repeat (3) adv();
    n_cmp++;
    if (bus.bcd !== 8'h37) begin
      n_bad++;
      $display("FAIL preload_37: got bcd=%h, want 37", bus.bcd);
    end

    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.bcd, bus.tick} !== 9'h000) begin
      n_bad++;
      $display("FAIL async_reset: got bcd=%h tick=%b, want 00/0", bus.bcd, bus.tick);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    for (int k = 1; k <= 10; k++) begin
      adv();
      n_cmp++;
      if ({bus.bcd, bus.tick} !== {(k == 10) ? 8'h01 : 8'h00, k == 10}) begin
        n_bad++;
        $display("FAIL first_tick_%0d: got bcd=%h tick=%b, want bcd=%h tick=%b",
                 k, bus.bcd, bus.tick, (k == 10) ? 8'h01 : 8'h00, k == 10);
      end
    end
  endtask

  task automatic test_up_count();
    int n_roll = 0;
    drive(0, 1, 1, 0, 8'h00);
    adv();
    drive(1, 1, 0, 0, 8'h00);
    for (int k = 0; k < 100 * PRESCALE; k++) begin
      adv();
      if (bus.rollover === 1'b1) n_roll++;
      n_cmp++;
      if ({bus.bcd, bus.tick, bus.rollover} !== {to_bcd(m_cnt), m_tick, m_roll}) begin
        n_bad++;
        $display("FAIL up_count: got bcd=%h tick=%b roll=%b, want bcd=%h tick=%b roll=%b",
                 bus.bcd, bus.tick, bus.rollover, to_bcd(m_cnt), m_tick, m_roll);
      end
    end
    n_cmp++;
    if (n_roll != 1) begin
      n_bad++;
      $display("FAIL up_rollover_count: got %0d rollover cycles, want 1", n_roll);
    end
  endtask

  task automatic test_down_count();
    drive(0, 0, 1, 0, 8'h00);
    adv();
    drive(1, 0, 0, 0, 8'h00);
    for (int k = 0; k < 25; k++) begin
      adv();
      n_cmp++;
      if ({bus.bcd, bus.tick, bus.rollover} !== {to_bcd(m_cnt), m_tick, m_roll}) begin
        n_bad++;
        $display("FAIL down_count: got bcd=%h tick=%b roll=%b, want bcd=%h tick=%b roll=%b",
                 bus.bcd, bus.tick, bus.rollover, to_bcd(m_cnt), m_tick, m_roll);
      end
    end
    drive(1, 0, 0, 1, 8'h10);
    adv();
    drive(1, 0, 0, 0, 8'h00);
    repeat (PRESCALE) adv();
    n_cmp++;
    if ({bus.bcd, bus.tick, bus.rollover} !== {8'h09, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL down_borrow: got bcd=%h tick=%b roll=%b, want 09/1/0", bus.bcd, bus.tick, bus.rollover);
    end
  endtask

  task automatic test_hold();
    drive(0, 1, 1, 0, 8'h00);
    adv();
    drive(1, 1, 0, 0, 8'h00);
    repeat (4) adv();
    drive(0, 1, 0, 0, 8'h00);
    for (int k = 0; k < 25; k++) begin
      adv();
      n_cmp++;
      if ({bus.bcd, bus.tick, bus.rollover} !== {to_bcd(m_cnt), m_tick, m_roll}) begin
        n_bad++;
        $display("FAIL hold: got bcd=%h tick=%b, want bcd=%h tick=%b", bus.bcd, bus.tick, to_bcd(m_cnt), m_tick);
      end
    end
    drive(1, 1, 0, 0, 8'h00);
    for (int k = 1; k <= 6; k++) begin
      adv();
      n_cmp++;
      if ({bus.bcd, bus.tick} !== {(k == 6) ? 8'h01 : 8'h00, k == 6}) begin
        n_bad++;
        $display("FAIL resume_%0d: got bcd=%h tick=%b, want bcd=%h tick=%b",
                 k, bus.bcd, bus.tick, (k == 6) ? 8'h01 : 8'h00, k == 6);
      end
    end
  endtask

  task automatic test_load_terminal();
    drive(0, 1, 1, 0, 8'h00);
    adv();
    drive(1, 1, 0, 0, 8'h00);
    repeat (PRESCALE - 1) adv();
    drive(1, 1, 0, 1, 8'h5C);
    adv();
    n_cmp++;
    if ({bus.bcd, bus.tick} !== {8'h59, 1'b0}) begin
      n_bad++;
      $display("FAIL load_on_terminal: got bcd=%h tick=%b, want 59/0", bus.bcd, bus.tick);
    end
    drive(1, 1, 0, 0, 8'h00);
    repeat (PRESCALE) adv();
    n_cmp++;
    if ({bus.bcd, bus.tick} !== {8'h60, 1'b1}) begin
      n_bad++;
      $display("FAIL tick_after_load: got bcd=%h tick=%b, want 60/1", bus.bcd, bus.tick);
    end
  endtask

  task automatic test_clear_load();
    drive(0, 1, 0, 1, 8'h42);
    adv();
    drive(0, 1, 1, 1, 8'h77);
    adv();
    n_cmp++;
    if ({bus.bcd, bus.tick} !== {to_bcd(m_cnt), m_tick} || bus.bcd !== 8'h00) begin
      n_bad++;
      $display("FAIL clear_over_load: got bcd=%h tick=%b, want 00/0", bus.bcd, bus.tick);
    end
`ifdef SEVEN_SEG_EN
    n_cmp++;
    if (bus.hex !== 14'h2040) begin
      n_bad++;
      $display("FAIL hex_zero: got hex=%h, want 2040", bus.hex);
    end
`endif
    drive(0, 1, 0, 0, 8'h00);
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      drive($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)),
            $urandom_range(0, 99) == 0, $urandom_range(0, 49) == 0, 8'($urandom));
      adv();
      n_cmp++;
      if ({bus.bcd, bus.tick, bus.rollover} !== {to_bcd(m_cnt), m_tick, m_roll}) begin
        n_bad++;
        $display("FAIL random_%0d: got bcd=%h tick=%b roll=%b, want bcd=%h tick=%b roll=%b",
                 k, bus.bcd, bus.tick, bus.rollover, to_bcd(m_cnt), m_tick, m_roll);
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_down_count();
    test_hold();
    test_load_terminal();
    test_clear_load();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
